// File: rtl/nmr_pkg.sv
// Shared constants and helpers for the N-modular-redundancy voter.
// Imported by the voter top and its per-bit vote slice.
package nmr_pkg;

    localparam int NMR_MAX_N = 15;
    localparam int NMR_CNT_W = 4;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/nmr_voter_bit_vote.sv
// One bit slice of the majority vote: counts enabled ones and zeros.
// A tie, including no enabled voters, keeps the previous voted bit.
module nmr_bit_vote
    import nmr_pkg::*;
#(
    parameter int N = 9
) (
    input  logic [N-1:0] i_data,
    input  logic [N-1:0] i_en,
    input  logic         i_prev,
    output logic         o_vote,
    output logic         o_tie
);

    localparam int CW = clog2(N + 1);

    logic [CW-1:0] w_ones;
    logic [CW-1:0] w_zeros;

    always_comb begin
        w_ones  = '0;
        w_zeros = '0;
        for (int r = 0; r < N; r++) begin
            if (i_en[r]) begin
                if (i_data[r]) w_ones  = w_ones + CW'(1);
                else           w_zeros = w_zeros + CW'(1);
            end
        end
    end

    assign o_tie  = (w_ones == w_zeros);
    assign o_vote = (w_ones > w_zeros) ? 1'b1 :
                    (w_zeros > w_ones) ? 1'b0 : i_prev;

endmodule

// File: rtl/nmr_voter.sv
// Registered per-bit majority voter over N replicas with strike-based
// per-bit fault isolation and a software-clearable fault mask.
module nmr_voter
    import nmr_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int N       = 9,
    parameter int STRIKES = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic [N*WIDTH-1:0] replica_data,
    input  logic               clear_mask,
    output logic               out_valid,
    output logic [WIDTH-1:0]   voted,
    output logic               no_majority,
    output logic [N*WIDTH-1:0] fault_mask,
    output logic [N-1:0]       replica_dead,
    output logic               fault_event
);

    localparam logic [NMR_CNT_W-1:0] CNT_LAST = NMR_CNT_W'(STRIKES - 1);

    logic [WIDTH-1:0] w_vote;
    logic [WIDTH-1:0] w_tie;
    logic [N-1:0]     w_set;

    for (genvar b = 0; b < WIDTH; b++) begin : g_bit
        logic [N-1:0] w_d;
        logic [N-1:0] w_e;

        always_comb begin
            w_d = '0;
            w_e = '0;
            for (int r = 0; r < N; r++) begin
                w_d[r] = replica_data[r*WIDTH + b];
                w_e[r] = ~fault_mask[r*WIDTH + b];
            end
        end

        nmr_bit_vote #(.N(N)) u_bit (
            .i_data (w_d),
            .i_en   (w_e),
            .i_prev (voted[b]),
            .o_vote (w_vote[b]),
            .o_tie  (w_tie[b])
        );
    end

    for (genvar r = 0; r < N; r++) begin : g_rep
        logic [NMR_CNT_W-1:0] r_cnt;
        logic [WIDTH-1:0]     r_acc;
        logic [WIDTH-1:0]     r_msk;
        logic                 r_dead;
        logic [NMR_CNT_W-1:0] w_cnt_nxt;
        logic [WIDTH-1:0]     w_acc_nxt;
        logic [WIDTH-1:0]     w_msk_nxt;
        logic [WIDTH-1:0]     w_mm;

        always_comb begin
            w_mm      = (replica_data[r*WIDTH +: WIDTH] ^ w_vote) & ~r_msk;
            w_cnt_nxt = r_cnt;
            w_acc_nxt = r_acc;
            w_msk_nxt = r_msk;
            if (clear_mask) begin
                w_cnt_nxt = '0;
                w_acc_nxt = '0;
                w_msk_nxt = '0;
            end else if (in_valid) begin
                if (w_mm == '0) begin
                    w_cnt_nxt = '0;
                    w_acc_nxt = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_msk_nxt = r_msk | r_acc | w_mm;
                    w_cnt_nxt = '0;
                    w_acc_nxt = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                    w_acc_nxt = r_acc | w_mm;
                end
            end
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_cnt  <= '0;
                r_acc  <= '0;
                r_msk  <= '0;
                r_dead <= 1'b0;
            end else begin
                r_cnt  <= w_cnt_nxt;
                r_acc  <= w_acc_nxt;
                r_msk  <= w_msk_nxt;
                r_dead <= &w_msk_nxt;
            end
        end

        assign w_set[r] = |(w_msk_nxt & ~r_msk);
        assign fault_mask[r*WIDTH +: WIDTH] = r_msk;
        assign replica_dead[r] = r_dead;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid   <= 1'b0;
            voted       <= '0;
            no_majority <= 1'b0;
            fault_event <= 1'b0;
        end else begin
            out_valid   <= in_valid;
            fault_event <= |w_set;
            if (in_valid) begin
                voted       <= w_vote;
                no_majority <= |w_tie;
            end
        end
    end

endmodule

// File: tb/tb_nmr_voter.sv
// Directed-vector bench for nmr_voter: an N=3 and an N=5 instance,
// both WIDTH=8, STRIKES=3, sharing clock and reset.
module tb_nmr_voter;

    logic clk = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    logic        a_valid, a_clear, a_ov, a_nm, a_fe;
    logic [23:0] a_data, a_fm;
    logic [7:0]  a_voted;
    logic [2:0]  a_dead;

    logic        b_valid, b_clear, b_ov, b_nm, b_fe;
    logic [39:0] b_data, b_fm;
    logic [7:0]  b_voted;
    logic [4:0]  b_dead;

    int n_run  = 0;
    int n_fail = 0;

    nmr_voter #(.WIDTH(8), .N(3), .STRIKES(3)) u_a (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (a_valid),
        .replica_data (a_data),
        .clear_mask   (a_clear),
        .out_valid    (a_ov),
        .voted        (a_voted),
        .no_majority  (a_nm),
        .fault_mask   (a_fm),
        .replica_dead (a_dead),
        .fault_event  (a_fe)
    );

    nmr_voter #(.WIDTH(8), .N(5), .STRIKES(3)) u_b (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (b_valid),
        .replica_data (b_data),
        .clear_mask   (b_clear),
        .out_valid    (b_ov),
        .voted        (b_voted),
        .no_majority  (b_nm),
        .fault_mask   (b_fm),
        .replica_dead (b_dead),
        .fault_event  (b_fe)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_run++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic a_set(input logic [7:0] d0, input logic [7:0] d1,
                         input logic [7:0] d2);
        a_data = {d2, d1, d0};
    endtask

    initial begin
        a_valid = 1'b0;
        a_clear = 1'b0;
        a_data  = '0;
        b_valid = 1'b0;
        b_clear = 1'b0;
        b_data  = '0;

        #1 reset = 1'b0;
        #2;
        chk("rst_voted", 64'(a_voted), 64'h0);
        chk("rst_ov", 64'(a_ov), 64'h0);
        chk("rst_nm", 64'(a_nm), 64'h0);
        chk("rst_fm", 64'(a_fm), 64'h0);
        chk("rst_dead", 64'(a_dead), 64'h0);
        chk("rst_fe", 64'(a_fe), 64'h0);
        step;
        reset = 1'b1;

        // Unanimous sample
        a_valid = 1'b1;
        a_set(8'hA5, 8'hA5, 8'hA5);
        step;
        chk("agree_voted", 64'(a_voted), 64'hA5);
        chk("agree_ov", 64'(a_ov), 64'h1);
        chk("agree_nm", 64'(a_nm), 64'h0);
        chk("agree_fm", 64'(a_fm), 64'h0);
        chk("agree_fe", 64'(a_fe), 64'h0);

        // Two strikes then agreement: counter must restart
        a_set(8'hA5, 8'hA5, 8'hA4);
        step;
        chk("s1_voted", 64'(a_voted), 64'hA5);
        step;
        chk("s2_fm", 64'(a_fm), 64'h0);
        a_set(8'hA5, 8'hA5, 8'hA5);
        step;
        chk("s2_agree_fm", 64'(a_fm), 64'h0);
        a_set(8'hA5, 8'hA5, 8'hA4);
        step;
        step;
        chk("cnt_restart_fm", 64'(a_fm), 64'h0);
        step;
        chk("mask_set_fm", 64'(a_fm), 64'h010000);
        chk("mask_set_fe", 64'(a_fe), 64'h1);
        chk("mask_set_voted", 64'(a_voted), 64'hA5);
        chk("mask_set_dead", 64'(a_dead), 64'h0);
        step;
        chk("fe_pulse", 64'(a_fe), 64'h0);
        step;
        step;
        chk("masked_fm", 64'(a_fm), 64'h010000);
        chk("masked_fe", 64'(a_fe), 64'h0);
        chk("masked_voted", 64'(a_voted), 64'hA5);

        // Bit0: r0=1, r1=0, r2 masked -> tie holds previous 1
        a_set(8'hA5, 8'hA4, 8'hA4);
        step;
        chk("tie_voted", 64'(a_voted), 64'hA5);
        chk("tie_nm", 64'(a_nm), 64'h1);

        // Idle cycle: outputs hold, out_valid drops
        a_valid = 1'b0;
        a_set(8'h00, 8'h00, 8'h00);
        step;
        chk("idle_ov", 64'(a_ov), 64'h0);
        chk("idle_voted", 64'(a_voted), 64'hA5);
        chk("idle_nm", 64'(a_nm), 64'h1);
        a_valid = 1'b1;
        a_set(8'h3C, 8'h3C, 8'h3C);
        step;
        chk("resume_ov", 64'(a_ov), 64'h1);
        chk("resume_voted", 64'(a_voted), 64'h3C);
        chk("resume_nm", 64'(a_nm), 64'h0);

        // Software clear
        a_clear = 1'b1;
        step;
        a_clear = 1'b0;
        chk("clear_fm", 64'(a_fm), 64'h0);
        chk("clear_voted", 64'(a_voted), 64'h3C);
        chk("clear_ov", 64'(a_ov), 64'h1);

        // Build mask plus pending strikes, then async reset
        a_set(8'h3C, 8'h3C, 8'h3D);
        step;
        step;
        step;
        chk("remask_fm", 64'(a_fm), 64'h010000);
        a_set(8'h3C, 8'h3E, 8'h3C);
        step;
        step;
        chk("pending_fm", 64'(a_fm), 64'h010000);
        reset = 1'b0;
        #2;
        chk("arst_voted", 64'(a_voted), 64'h0);
        chk("arst_ov", 64'(a_ov), 64'h0);
        chk("arst_fm", 64'(a_fm), 64'h0);
        chk("arst_dead", 64'(a_dead), 64'h0);
        step;
        reset = 1'b1;
        step;
        chk("post_rst_fm", 64'(a_fm), 64'h0);
        chk("post_rst_voted", 64'(a_voted), 64'h3C);
        chk("post_rst_ov", 64'(a_ov), 64'h1);
        a_valid = 1'b0;

        // N=5: replica 4 inverted for three samples
        b_valid = 1'b1;
        b_data  = {8'hA5, 8'h5A, 8'h5A, 8'h5A, 8'h5A};
        step;
        chk("b_voted", 64'(b_voted), 64'h5A);
        step;
        chk("b_s2_fm", 64'(b_fm), 64'h0);
        step;
        chk("b_dead_fm", 64'(b_fm), 64'hFF00000000);
        chk("b_dead", 64'(b_dead), 64'h10);
        chk("b_dead_fe", 64'(b_fe), 64'h1);
        step;
        chk("b_fe_pulse", 64'(b_fe), 64'h0);
        chk("b_dead_voted", 64'(b_voted), 64'h5A);

        b_valid = 1'b0;
        b_clear = 1'b1;
        step;
        b_clear = 1'b0;
        chk("b_clr_fm", 64'(b_fm), 64'h0);
        chk("b_clr_dead", 64'(b_dead), 64'h0);

        // Clear in the same cycle as the third strike wins
        b_valid = 1'b1;
        step;
        step;
        b_clear = 1'b1;
        step;
        b_clear = 1'b0;
        chk("b_clr_win_fm", 64'(b_fm), 64'h0);
        chk("b_clr_win_fe", 64'(b_fe), 64'h0);
        chk("b_clr_win_voted", 64'(b_voted), 64'h5A);
        step;
        chk("b_clr_cnt_fm", 64'(b_fm), 64'h0);
        b_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
